// File: rtl/rtc_counter.sv
// rtc_counter: real-time clock counter for the RTC clock domain.
// Keeps a 62-bit fractional nanosecond accumulator ([61:32] ns, [31:0] fraction),
// a 48-bit seconds counter, a bounded frequency/phase adjust window and an
// optional one-pulse-per-second output.
// Optional feature macro: RTC_ONE_PPS_EN (defined: one_pps_out pulses for
// PPS_WIDTH cycles on every second rollover; undefined: one_pps_out tied 0).
module rtc_counter #(
  parameter int unsigned PPS_WIDTH = 1  // one_pps_out pulse length in clk cycles (1..255)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        time_ld_in,
  input  logic [37:0] time_reg_ns_in,
  input  logic [47:0] time_reg_sec_in,
  input  logic        period_ld_in,
  input  logic [39:0] period_in,
  input  logic [37:0] time_acc_modulo_in,
  input  logic        adj_ld_in,
  input  logic [31:0] adj_ld_data_in,
  input  logic [39:0] period_adj_in,
  output logic [37:0] time_reg_ns_out,
  output logic [47:0] time_reg_sec_out,
  output logic        adj_busy_out,
  output logic        one_pps_out
);

  // Architectural state
  logic [61:0] r_acc;
  logic [47:0] r_sec;
  logic [39:0] r_period;
  logic [39:0] r_period_adj;
  logic [31:0] r_adj_cnt;
  logic        r_adj_busy;

  // Datapath and next-state signals
  logic [61:0] w_mod;
  logic [61:0] w_inc;
  logic [62:0] w_sum;
  logic [61:0] w_wrapped;
  logic        w_roll;
  logic [61:0] w_acc_nxt;
  logic [47:0] w_sec_nxt;
  logic [31:0] w_adj_cnt_nxt;
  logic [39:0] w_period_adj_nxt;

  // The modulo is sampled live, expanded to the accumulator's fixed-point format.
  assign w_mod = {time_acc_modulo_in, 24'd0};

  // Per-tick increment; the adjust term applies only while the window is open.
  // The sum is one bit wider than the accumulator so the compare never truncates.
  assign w_inc     = {22'd0, r_period} + ((r_adj_cnt != 32'd0) ? {22'd0, r_period_adj} : 62'd0);
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_inc};
  assign w_roll    = (w_sum >= {1'b0, w_mod});
  // Modular subtraction on the low 62 bits gives the same result as the wide one.
  assign w_wrapped = w_sum[61:0] - w_mod;

  // Next-state for time: load wins over tick; a single modulo subtraction per tick.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    w_acc_nxt = r_acc;
    w_sec_nxt = r_sec;
    if (time_ld_in) begin
      w_acc_nxt = {time_reg_ns_in, 24'd0};
      w_sec_nxt = time_reg_sec_in;
    end else if (w_roll) begin
      w_acc_nxt = w_wrapped;
      w_sec_nxt = r_sec + 48'd1;  // wraps 2^48-1 -> 0 naturally
    end else begin
      w_acc_nxt = w_sum[61:0];
    end
  end

  // Next-state for the adjust window: a load overrides the decrement and data 0 ends it.
  always_comb begin
    w_adj_cnt_nxt    = r_adj_cnt;
    w_period_adj_nxt = r_period_adj;
    if (adj_ld_in) begin
      w_adj_cnt_nxt    = adj_ld_data_in;
      w_period_adj_nxt = period_adj_in;
    end else if (r_adj_cnt != 32'd0) begin
      w_adj_cnt_nxt = r_adj_cnt - 32'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_acc        <= '0;
      r_sec        <= '0;
      r_period     <= '0;
      r_period_adj <= '0;
      r_adj_cnt    <= '0;
      r_adj_busy   <= 1'b0;
    end else begin
      r_acc        <= w_acc_nxt;
      r_sec        <= w_sec_nxt;
      r_period_adj <= w_period_adj_nxt;
      r_adj_cnt    <= w_adj_cnt_nxt;
      r_adj_busy   <= (w_adj_cnt_nxt != 32'd0);
      if (period_ld_in) begin
        r_period <= period_in;
      end
    end
  end

  assign time_reg_ns_out  = r_acc[61:24];
  assign time_reg_sec_out = r_sec;
  assign adj_busy_out     = r_adj_busy;

`ifdef RTC_ONE_PPS_EN
  localparam logic [7:0] PPS_LOAD = 8'(PPS_WIDTH);

  logic [7:0] r_pps_cnt;
  logic       r_pps;
  logic [7:0] w_pps_cnt_nxt;

  // Pulse counter: a rollover tick (not masked by a time load) reloads, otherwise count down.
  always_comb begin
    w_pps_cnt_nxt = r_pps_cnt;
    if (!time_ld_in && w_roll) begin
      w_pps_cnt_nxt = PPS_LOAD;
    end else if (r_pps_cnt != 8'd0) begin
      w_pps_cnt_nxt = r_pps_cnt - 8'd1;
    end
  end

  // Pulse registers; the flag rises together with the incremented seconds.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pps_cnt <= '0;
      r_pps     <= 1'b0;
    end else begin
      r_pps_cnt <= w_pps_cnt_nxt;
      r_pps     <= (w_pps_cnt_nxt != 8'd0);
    end
  end

  assign one_pps_out = r_pps;
`else
  // Keeps PPS_WIDTH referenced in builds without the pulse output.
  logic w_unused_pps;
  assign w_unused_pps = (PPS_WIDTH != 0);
  assign one_pps_out  = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_counter.sv
// tb_rtc_counter: directed scoreboard bench for rtc_counter.
// The stimulus process pushes the expected outputs for the next clock edge
// into a queue; an independent monitor pops and compares after each edge.
`timescale 1ns/1ps
module tb_rtc_counter;

  localparam int unsigned PPS_W = 3;
`ifdef RTC_ONE_PPS_EN
  localparam logic P = 1'b1;
`else
  localparam logic P = 1'b0;
`endif

  localparam logic [37:0] MOD    = 38'h3B9ACA0000;  // 1e9 ns
  localparam logic [37:0] NS_M16 = 38'h3B9AC9F000;  // 999999984 ns
  localparam logic [37:0] NS_M8  = 38'h3B9AC9F800;  // 999999992 ns
  localparam logic [37:0] NS_8   = 38'h800;
  localparam logic [37:0] NS_10  = 38'hA00;
  localparam logic [37:0] NS_85  = 38'h880;         // 8.5 ns
  localparam logic [39:0] PER_8  = 40'h08_0000_0000;
  localparam logic [39:0] PER_10 = 40'h0A_0000_0000;
  localparam logic [39:0] ADJ_H  = 40'h00_8000_0000;

  logic        clk;
  logic        rst;
  logic        time_ld_in;
  logic [37:0] time_reg_ns_in;
  logic [47:0] time_reg_sec_in;
  logic        period_ld_in;
  logic [39:0] period_in;
  logic [37:0] time_acc_modulo_in;
  logic        adj_ld_in;
  logic [31:0] adj_ld_data_in;
  logic [39:0] period_adj_in;
  logic [37:0] time_reg_ns_out;
  logic [47:0] time_reg_sec_out;
  logic        adj_busy_out;
  logic        one_pps_out;

  rtc_counter #(.PPS_WIDTH(PPS_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .time_ld_in        (time_ld_in),
    .time_reg_ns_in    (time_reg_ns_in),
    .time_reg_sec_in   (time_reg_sec_in),
    .period_ld_in      (period_ld_in),
    .period_in         (period_in),
    .time_acc_modulo_in(time_acc_modulo_in),
    .adj_ld_in         (adj_ld_in),
    .adj_ld_data_in    (adj_ld_data_in),
    .period_adj_in     (period_adj_in),
    .time_reg_ns_out   (time_reg_ns_out),
    .time_reg_sec_out  (time_reg_sec_out),
    .adj_busy_out      (adj_busy_out),
    .one_pps_out       (one_pps_out)
  );

  typedef struct {
    int unsigned tag;
    string       name;
    logic [37:0] ns;
    logic [47:0] sec;
    logic        busy;
    logic        pps;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [37:0] m_ns;
  logic [47:0] m_sec;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: after each edge compare every expectation due at this cycle.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    while (exp_q.size() != 0 && exp_q[0].tag <= cyc) begin
      e = exp_q.pop_front();
      if (e.tag != cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s stale: due cycle %0d, seen cycle %0d", e.name, e.tag, cyc);
      end else begin
        check({e.name, " ns"},   64'(time_reg_ns_out),  64'(e.ns));
        check({e.name, " sec"},  64'(time_reg_sec_out), 64'(e.sec));
        check({e.name, " busy"}, 64'(adj_busy_out),     64'(e.busy));
        check({e.name, " pps"},  64'(one_pps_out),      64'(e.pps));
      end
    end
  end

  // Queue the outputs required right after the coming edge.
  task automatic expect_out(input string nm, input logic busy, input logic pps);
    exp_t e;
    e.tag  = cyc + 1;
    e.name = nm;
    e.ns   = m_ns;
    e.sec  = m_sec;
    e.busy = busy;
    e.pps  = pps;
    exp_q.push_back(e);
  endtask

  // Advance to the next falling edge and retire the single-cycle strobes.
  task automatic next_cycle();
    @(negedge clk);
    time_ld_in   = 1'b0;
    period_ld_in = 1'b0;
    adj_ld_in    = 1'b0;
  endtask

  task automatic load_time(input logic [37:0] ns, input logic [47:0] sec);
    time_ld_in      = 1'b1;
    time_reg_ns_in  = ns;
    time_reg_sec_in = sec;
  endtask

  task automatic load_adj(input logic [31:0] cnt, input logic [39:0] padj);
    adj_ld_in      = 1'b1;
    adj_ld_data_in = cnt;
    period_adj_in  = padj;
  endtask

  initial begin
    rst                = 1'b1;
    time_ld_in         = 1'b0;
    time_reg_ns_in     = '0;
    time_reg_sec_in    = '0;
    period_ld_in       = 1'b0;
    period_in          = '0;
    time_acc_modulo_in = MOD;
    adj_ld_in          = 1'b0;
    adj_ld_data_in     = '0;
    period_adj_in      = '0;
    m_ns               = '0;
    m_sec              = '0;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 2; i++) begin
      expect_out("reset", 1'b0, 1'b0);
      next_cycle();
    end

    // Free run: load-cycle tick uses the reset period (0), then 8 ns per tick
    rst = 1'b0;
    period_ld_in = 1'b1;
    period_in    = PER_8;
    expect_out("period_ld0", 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      m_ns += NS_8;
      expect_out("free_run", 1'b0, 1'b0);
      next_cycle();
    end

    // Period change: the load-cycle tick still adds the old period
    period_ld_in = 1'b1;
    period_in    = PER_10;
    m_ns += NS_8;
    expect_out("period10_ld", 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      m_ns += NS_10;
      expect_out("period10_run", 1'b0, 1'b0);
      next_cycle();
    end
    period_ld_in = 1'b1;
    period_in    = PER_8;
    m_ns += NS_10;
    expect_out("period8_ld", 1'b0, 1'b0);
    next_cycle();
    m_ns += NS_8;
    expect_out("period8_run", 1'b0, 1'b0);
    next_cycle();

    // Adjust window of 4 ticks at +0.5 ns each
    load_adj(32'd4, ADJ_H);
    m_ns += NS_8;
    expect_out("adj_ld", 1'b1, 1'b0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      m_ns += NS_85;
      expect_out("adj_tick", (i < 3), 1'b0);
      next_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      m_ns += NS_8;
      expect_out("adj_done", 1'b0, 1'b0);
      next_cycle();
    end

    // Rollover from 999999984 ns, sec 5
    load_time(NS_M16, 48'd5);
    m_ns = NS_M16; m_sec = 48'd5;
    expect_out("roll_ld", 1'b0, 1'b0);
    next_cycle();
    m_ns = NS_M8;
    expect_out("roll_pre", 1'b0, 1'b0);
    next_cycle();
    m_ns = '0; m_sec = 48'd6;
    expect_out("roll_edge", 1'b0, P);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      m_ns += NS_8;
      expect_out("roll_pps", 1'b0, (i < 2) ? P : 1'b0);
      next_cycle();
    end

    // Seconds wrap, then a rollover during an active pulse reloads it
    load_time(NS_M8, 48'hFFFF_FFFF_FFFF);
    m_ns = NS_M8; m_sec = 48'hFFFF_FFFF_FFFF;
    expect_out("wrap_ld", 1'b0, 1'b0);
    next_cycle();
    m_ns = '0; m_sec = '0;
    expect_out("wrap_edge", 1'b0, P);
    next_cycle();
    load_time(NS_M8, 48'd9);
    m_ns = NS_M8; m_sec = 48'd9;
    expect_out("reload_ld", 1'b0, P);
    next_cycle();
    m_ns = '0; m_sec = 48'd10;
    expect_out("reload_edge", 1'b0, P);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      m_ns += NS_8;
      expect_out("reload_pps", 1'b0, (i < 2) ? P : 1'b0);
      next_cycle();
    end

    // Time load on the rollover tick wins: no increment, no pulse
    load_time(NS_M8, 48'd7);
    m_ns = NS_M8; m_sec = 48'd7;
    expect_out("simul_pre", 1'b0, 1'b0);
    next_cycle();
    load_time(38'h1000, 48'd100);
    m_ns = 38'h1000; m_sec = 48'd100;
    expect_out("simul_ld", 1'b0, 1'b0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      m_ns += NS_8;
      expect_out("simul_after", 1'b0, 1'b0);
      next_cycle();
    end

    // Window termination with data 0, then reset during a window
    load_adj(32'd10, ADJ_H);
    m_ns += NS_8;
    expect_out("adj10_ld", 1'b1, 1'b0);
    next_cycle();
    m_ns += NS_85;
    expect_out("adj10_tick", 1'b1, 1'b0);
    next_cycle();
    load_adj(32'd0, ADJ_H);
    m_ns += NS_85;
    expect_out("adj_stop", 1'b0, 1'b0);
    next_cycle();
    m_ns += NS_8;
    expect_out("adj_stopped", 1'b0, 1'b0);
    next_cycle();
    load_adj(32'd6, ADJ_H);
    m_ns += NS_8;
    expect_out("adj6_ld", 1'b1, 1'b0);
    next_cycle();
    m_ns += NS_85;
    expect_out("adj6_tick", 1'b1, 1'b0);
    next_cycle();
    rst = 1'b1;
    load_time(38'h1234, 48'd55);
    m_ns = '0; m_sec = '0;
    expect_out("rst_in_adj", 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      expect_out("post_rst", 1'b0, 1'b0);
      next_cycle();
    end

    next_cycle();
    next_cycle();
    check("queue drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
